// File: rtl/lane_regfile_pkg.sv
// lane_regfile_pkg: shared types, constants and helpers for the packed-lane
// register file.
package lane_regfile_pkg;

  // Fill-engine states: IDLE accepts writes, SWEEP restores one lane per cycle
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } fsm_e;

  // Wide all-ones source; the top slices it to the lane width for FILL
  localparam logic [255:0] FILL_ONES = '1;

  // True when a lane index addresses real storage
  function automatic logic lane_in_range(input logic [31:0] addr,
                                         input logic [31:0] lanes);
    return addr < lanes;
  endfunction

endpackage

// File: rtl/lane_regfile_if.sv
// lane_regfile_if: write, read, fill, error and frame signals of the
// register file, bundled so the host and the file share one connection.
interface lane_regfile_if #(
  parameter int LANES = 4,
  parameter int W     = 8,
  parameter int AW    = 3
);
  logic                   wr_valid_i;
  logic [AW-1:0]          wr_addr_i;
  logic [W-1:0]           wr_data_i;
  logic [W-1:0]           wr_mask_i;
  logic                   rd_valid_i;
  logic [AW-1:0]          rd_addr_i;
  logic                   rd_valid_o;
  logic [W-1:0]           rd_data_o;
  logic                   rd_oor_o;
  logic                   fill_i;
  logic                   busy_o;
  logic                   err_o;
  logic                   clear_i;
  logic [(LANES+2)*W-1:0] frame_o;

  modport master (
    output wr_valid_i, wr_addr_i, wr_data_i, wr_mask_i,
    output rd_valid_i, rd_addr_i, fill_i, clear_i,
    input  rd_valid_o, rd_data_o, rd_oor_o, busy_o, err_o, frame_o
  );

  modport slave (
    input  wr_valid_i, wr_addr_i, wr_data_i, wr_mask_i,
    input  rd_valid_i, rd_addr_i, fill_i, clear_i,
    output rd_valid_o, rd_data_o, rd_oor_o, busy_o, err_o, frame_o
  );
endinterface

// File: rtl/lane_regfile_merge.sv
// lane_merge: per-bit masked merge, new = (old & ~mask) | (data & mask).
module lane_merge #(
  parameter int W = 8
) (
  input  logic [W-1:0] old_i,
  input  logic [W-1:0] data_i,
  input  logic [W-1:0] mask_i,
  output logic [W-1:0] new_o
);

  // Masked bits take the new data, the rest keep the old lane contents
  always_comb begin
    new_o = (old_i & ~mask_i) | (data_i & mask_i);
  end

endmodule

// File: rtl/lane_regfile.sv
// lane_regfile: packed frame {hdr, data[0:LANES-1], trl} with one masked
// write port, one registered read port and a lane-by-lane fill engine.
// Optional feature macro: LANE_REGFILE_BYPASS_EN -- a read of the lane being
// written (or swept) in the same cycle returns the new value instead of the
// stored one.
module lane_regfile
  import lane_regfile_pkg::*;
#(
  parameter int            LANES = 4,
  parameter int            W     = 8,
  parameter int            AW    = 3,
  parameter logic [W-1:0]  FILL  = FILL_ONES[W-1:0]
) (
  input  logic          clk_i,
  input  logic          rst_i,
  lane_regfile_if.slave bus
);

  localparam int CW = (LANES > 1) ? $clog2(LANES) : 1;

  typedef struct packed {
    logic [W-1:0]              hdr;
    logic [0:LANES-1][W-1:0]   data;
    logic [W-1:0]              trl;
  } frame_t;

  frame_t        frame_q, frame_d;
  fsm_e          state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          rd_valid_q, rd_valid_d;
  logic [W-1:0]  rd_data_q, rd_data_d;
  logic          rd_oor_q, rd_oor_d;

  logic          wr_in_range;
  logic          rd_in_range;
  logic          wr_accept;
  logic [W-1:0]  wr_old;
  logic [W-1:0]  wr_new;
  logic [W-1:0]  rd_stored;

  assign wr_in_range = lane_in_range(32'(bus.wr_addr_i), 32'(LANES));
  assign rd_in_range = lane_in_range(32'(bus.rd_addr_i), 32'(LANES));
  assign wr_accept   = bus.wr_valid_i && wr_in_range && (state_q == IDLE);

  // Pick the currently stored lane for the write merge and for the read port
  always_comb begin
    wr_old    = '0;
    rd_stored = '0;
    for (int k = 0; k < LANES; k++) begin
      if (int'(bus.wr_addr_i) == k) wr_old = frame_q.data[k];
      if (int'(bus.rd_addr_i) == k) rd_stored = frame_q.data[k];
    end
  end

  lane_merge #(.W(W)) u_merge (
    .old_i  (wr_old),
    .data_i (bus.wr_data_i),
    .mask_i (bus.wr_mask_i),
    .new_o  (wr_new)
  );

  // Storage update and fill sequencing: writes only in IDLE, one lane per SWEEP cycle
  always_comb begin
    frame_d = frame_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (wr_accept) begin
          for (int k = 0; k < LANES; k++) begin
            if (int'(bus.wr_addr_i) == k) frame_d.data[k] = wr_new;
          end
        end
        if (bus.fill_i) begin
          state_d = SWEEP;
          cnt_d   = '0;
        end
      end
      SWEEP: begin
        for (int k = 0; k < LANES; k++) begin
          if (int'(cnt_q) == k) frame_d.data[k] = FILL;
        end
        if (int'(cnt_q) == LANES - 1) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Sticky error: a rejected write sets it, clear drops it, set wins a tie
  always_comb begin
    err_d = err_q;
    if (bus.clear_i) err_d = 1'b0;
    if (bus.wr_valid_i && (!wr_in_range || (state_q == SWEEP))) err_d = 1'b1;
  end

  // Read response: out-of-range gives zero and a flag, idle cycles hold data
  always_comb begin
    rd_valid_d = bus.rd_valid_i;
    rd_data_d  = rd_data_q;
    rd_oor_d   = rd_oor_q;
    if (bus.rd_valid_i) begin
      if (rd_in_range) begin
        rd_oor_d  = 1'b0;
        rd_data_d = rd_stored;
`ifdef LANE_REGFILE_BYPASS_EN
        if (wr_accept && (bus.wr_addr_i == bus.rd_addr_i)) rd_data_d = wr_new;
        if ((state_q == SWEEP) && (int'(cnt_q) == int'(bus.rd_addr_i))) rd_data_d = FILL;
`endif
      end else begin
        rd_oor_d  = 1'b1;
        rd_data_d = '0;
      end
    end
  end

  // Register everything; reset restores the fill pattern and an idle engine
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      frame_q    <= {FILL, {LANES{FILL}}, FILL};
      state_q    <= IDLE;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_oor_q   <= 1'b0;
    end else begin
      frame_q    <= frame_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      rd_oor_q   <= rd_oor_d;
    end
  end

  assign bus.frame_o    = frame_q;
  assign bus.rd_valid_o = rd_valid_q;
  assign bus.rd_data_o  = rd_data_q;
  assign bus.rd_oor_o   = rd_oor_q;
  assign bus.busy_o     = (state_q == SWEEP);
  assign bus.err_o      = err_q;

endmodule

// File: tb/tb_lane_regfile.sv
// tb_lane_regfile: directed scenarios for lane_regfile with LANES=4, W=8, AW=3.
module tb_lane_regfile;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_fail;

  lane_regfile_if #(.LANES(4), .W(8), .AW(3)) bus ();

  lane_regfile #(.LANES(4), .W(8), .AW(3)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  // Free-running clock, 10 time units per period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    bus.wr_valid_i = 1'b0;
    bus.wr_addr_i  = '0;
    bus.wr_data_i  = '0;
    bus.wr_mask_i  = '0;
    bus.rd_valid_i = 1'b0;
    bus.rd_addr_i  = '0;
    bus.fill_i     = 1'b0;
    bus.clear_i    = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    n_cmp++; if (bus.rd_valid_o !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_rd_valid: got %b want 0", bus.rd_valid_o); end
    n_cmp++; if (bus.rd_data_o !== 8'h00) begin n_fail++; $display("[TB] FAIL reset_rd_data: got %h want 00", bus.rd_data_o); end
    n_cmp++; if (bus.rd_oor_o !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_rd_oor: got %b want 0", bus.rd_oor_o); end
    n_cmp++; if (bus.busy_o !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %b want 0", bus.busy_o); end
    n_cmp++; if (bus.err_o !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_err: got %b want 0", bus.err_o); end
    n_cmp++; if (bus.frame_o !== 48'hffff_ffff_ffff) begin n_fail++; $display("[TB] FAIL reset_frame: got %h want ffffffffffff", bus.frame_o); end
    rst = 1'b0;
    bus.rd_valid_i = 1'b1;
    bus.rd_addr_i  = 3'd2;
    tick();
    bus.rd_valid_i = 1'b0;
    n_cmp++; if (bus.rd_valid_o !== 1'b1) begin n_fail++; $display("[TB] FAIL read2_valid: got %b want 1", bus.rd_valid_o); end
    n_cmp++; if (bus.rd_data_o !== 8'hff) begin n_fail++; $display("[TB] FAIL read2_data: got %h want ff", bus.rd_data_o); end
    n_cmp++; if (bus.rd_oor_o !== 1'b0) begin n_fail++; $display("[TB] FAIL read2_oor: got %b want 0", bus.rd_oor_o); end
    tick();
    n_cmp++; if (bus.rd_valid_o !== 1'b0) begin n_fail++; $display("[TB] FAIL idle_valid: got %b want 0", bus.rd_valid_o); end
    n_cmp++; if (bus.rd_data_o !== 8'hff) begin n_fail++; $display("[TB] FAIL idle_hold_data: got %h want ff", bus.rd_data_o); end
  endtask

  task automatic test_write;
    bus.wr_valid_i = 1'b1;
    bus.wr_addr_i  = 3'd1;
    bus.wr_data_i  = 8'h7e;
    bus.wr_mask_i  = 8'hff;
    tick();
    bus.wr_valid_i = 1'b0;
    n_cmp++; if (bus.frame_o !== 48'hffff_7eff_ffff) begin n_fail++; $display("[TB] FAIL write1_frame: got %h want ffff7effffff", bus.frame_o); end
    bus.rd_valid_i = 1'b1;
    bus.rd_addr_i  = 3'd1;
    tick();
    n_cmp++; if (bus.rd_data_o !== 8'h7e) begin n_fail++; $display("[TB] FAIL read1_data: got %h want 7e", bus.rd_data_o); end
    bus.rd_addr_i = 3'd2;
    tick();
    bus.rd_valid_i = 1'b0;
    n_cmp++; if (bus.rd_data_o !== 8'hff) begin n_fail++; $display("[TB] FAIL read2b_data: got %h want ff", bus.rd_data_o); end
    n_cmp++; if (bus.rd_valid_o !== 1'b1) begin n_fail++; $display("[TB] FAIL read2b_valid: got %b want 1", bus.rd_valid_o); end
  endtask

  task automatic test_out_of_range;
    bus.rd_valid_i = 1'b1;
    bus.rd_addr_i  = 3'd4;
    tick();
    bus.rd_valid_i = 1'b0;
    n_cmp++; if (bus.rd_data_o !== 8'h00) begin n_fail++; $display("[TB] FAIL oor_rd_data: got %h want 00", bus.rd_data_o); end
    n_cmp++; if (bus.rd_oor_o !== 1'b1) begin n_fail++; $display("[TB] FAIL oor_rd_flag: got %b want 1", bus.rd_oor_o); end
    bus.wr_valid_i = 1'b1;
    bus.wr_addr_i  = 3'd5;
    bus.wr_data_i  = 8'h00;
    bus.wr_mask_i  = 8'hff;
    tick();
    bus.wr_valid_i = 1'b0;
    n_cmp++; if (bus.err_o !== 1'b1) begin n_fail++; $display("[TB] FAIL oor_wr_err: got %b want 1", bus.err_o); end
    n_cmp++; if (bus.frame_o !== 48'hffff_7eff_ffff) begin n_fail++; $display("[TB] FAIL oor_wr_frame: got %h want ffff7effffff", bus.frame_o); end
    tick();
    n_cmp++; if (bus.err_o !== 1'b1) begin n_fail++; $display("[TB] FAIL err_sticky: got %b want 1", bus.err_o); end
    bus.clear_i = 1'b1;
    tick();
    bus.clear_i = 1'b0;
    n_cmp++; if (bus.err_o !== 1'b0) begin n_fail++; $display("[TB] FAIL err_clear: got %b want 0", bus.err_o); end
    bus.wr_valid_i = 1'b1;
    bus.wr_addr_i  = 3'd6;
    bus.clear_i    = 1'b1;
    tick();
    bus.wr_valid_i = 1'b0;
    bus.clear_i    = 1'b0;
    n_cmp++; if (bus.err_o !== 1'b1) begin n_fail++; $display("[TB] FAIL err_set_wins: got %b want 1", bus.err_o); end
    bus.clear_i = 1'b1;
    tick();
    bus.clear_i = 1'b0;
    n_cmp++; if (bus.err_o !== 1'b0) begin n_fail++; $display("[TB] FAIL err_clear2: got %b want 0", bus.err_o); end
  endtask

  task automatic test_mask;
    bus.wr_valid_i = 1'b1;
    bus.wr_addr_i  = 3'd0;
    bus.wr_data_i  = 8'h00;
    bus.wr_mask_i  = 8'h0f;
    tick();
    bus.wr_valid_i = 1'b0;
    bus.rd_valid_i = 1'b1;
    bus.rd_addr_i  = 3'd0;
    tick();
    bus.rd_valid_i = 1'b0;
    n_cmp++; if (bus.rd_data_o !== 8'hf0) begin n_fail++; $display("[TB] FAIL mask_read: got %h want f0", bus.rd_data_o); end
    n_cmp++; if (bus.frame_o !== 48'hfff0_7eff_ffff) begin n_fail++; $display("[TB] FAIL mask_frame: got %h want fff07effffff", bus.frame_o); end
  endtask

  task automatic test_same_lane;
    logic [7:0] exp_first;
`ifdef LANE_REGFILE_BYPASS_EN
    exp_first = 8'ha5;
`else
    exp_first = 8'hff;
`endif
    bus.wr_valid_i = 1'b1;
    bus.wr_addr_i  = 3'd3;
    bus.wr_data_i  = 8'ha5;
    bus.wr_mask_i  = 8'hff;
    bus.rd_valid_i = 1'b1;
    bus.rd_addr_i  = 3'd3;
    tick();
    bus.wr_valid_i = 1'b0;
    n_cmp++; if (bus.rd_data_o !== exp_first) begin n_fail++; $display("[TB] FAIL same_lane_read: got %h want %h", bus.rd_data_o, exp_first); end
    tick();
    bus.rd_valid_i = 1'b0;
    n_cmp++; if (bus.rd_data_o !== 8'ha5) begin n_fail++; $display("[TB] FAIL same_lane_next: got %h want a5", bus.rd_data_o); end
    n_cmp++; if (bus.frame_o !== 48'hfff0_7eff_a5ff) begin n_fail++; $display("[TB] FAIL same_lane_frame: got %h want fff07effa5ff", bus.frame_o); end
  endtask

  task automatic test_fill;
    int n;
    bus.fill_i = 1'b1;
    tick();
    bus.fill_i = 1'b0;
    n = 0;
    while (bus.busy_o === 1'b1 && n < 10) begin
      n++;
      if (n == 1) begin
        bus.wr_valid_i = 1'b1;
        bus.wr_addr_i  = 3'd2;
        bus.wr_data_i  = 8'h00;
        bus.wr_mask_i  = 8'hff;
      end
      if (n == 2) bus.fill_i = 1'b1;
      tick();
      bus.wr_valid_i = 1'b0;
      bus.fill_i     = 1'b0;
    end
    n_cmp++; if (n !== 4) begin n_fail++; $display("[TB] FAIL fill_busy_cycles: got %0d want 4", n); end
    n_cmp++; if (bus.err_o !== 1'b1) begin n_fail++; $display("[TB] FAIL fill_wr_err: got %b want 1", bus.err_o); end
    n_cmp++; if (bus.frame_o !== 48'hffff_ffff_ffff) begin n_fail++; $display("[TB] FAIL fill_frame: got %h want ffffffffffff", bus.frame_o); end
    bus.rd_valid_i = 1'b1;
    bus.rd_addr_i  = 3'd1;
    bus.clear_i    = 1'b1;
    tick();
    bus.rd_valid_i = 1'b0;
    bus.clear_i    = 1'b0;
    n_cmp++; if (bus.rd_data_o !== 8'hff) begin n_fail++; $display("[TB] FAIL fill_read1: got %h want ff", bus.rd_data_o); end
  endtask

  task automatic test_reset_mid_sweep;
    bus.wr_valid_i = 1'b1;
    bus.wr_addr_i  = 3'd2;
    bus.wr_data_i  = 8'h3c;
    bus.wr_mask_i  = 8'hff;
    tick();
    bus.wr_valid_i = 1'b0;
    n_cmp++; if (bus.frame_o !== 48'hffff_ff3c_ffff) begin n_fail++; $display("[TB] FAIL pre_sweep_frame: got %h want ffffff3cffff", bus.frame_o); end
    bus.fill_i = 1'b1;
    tick();
    bus.fill_i = 1'b0;
    n_cmp++; if (bus.busy_o !== 1'b1) begin n_fail++; $display("[TB] FAIL sweep_busy: got %b want 1", bus.busy_o); end
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++; if (bus.busy_o !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_mid_busy: got %b want 0", bus.busy_o); end
    n_cmp++; if (bus.frame_o !== 48'hffff_ffff_ffff) begin n_fail++; $display("[TB] FAIL rst_mid_frame: got %h want ffffffffffff", bus.frame_o); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] exp_data [5];
    logic       exp_oor  [5];
    exp_data = '{8'h11, 8'h22, 8'hff, 8'hff, 8'h00};
    exp_oor  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    bus.wr_valid_i = 1'b1;
    bus.wr_mask_i  = 8'hff;
    bus.wr_addr_i  = 3'd0;
    bus.wr_data_i  = 8'h11;
    tick();
    bus.wr_addr_i  = 3'd1;
    bus.wr_data_i  = 8'h22;
    tick();
    bus.wr_valid_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.rd_valid_i = 1'b1;
      bus.rd_addr_i  = 3'(i);
      tick();
      n_cmp++; if (bus.rd_valid_o !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_valid[%0d]: got %b want 1", i, bus.rd_valid_o); end
      n_cmp++; if (bus.rd_data_o !== exp_data[i]) begin n_fail++; $display("[TB] FAIL b2b_data[%0d]: got %h want %h", i, bus.rd_data_o, exp_data[i]); end
      n_cmp++; if (bus.rd_oor_o !== exp_oor[i]) begin n_fail++; $display("[TB] FAIL b2b_oor[%0d]: got %b want %b", i, bus.rd_oor_o, exp_oor[i]); end
    end
    bus.rd_valid_i = 1'b0;
    tick();
  endtask

  // Run every scenario in order, then report
  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rst    = 1'b1;
    idle_inputs();
    test_reset();
    test_write();
    test_out_of_range();
    test_mask();
    test_same_lane();
    test_fill();
    test_reset_mid_sweep();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/lane_regfile.md
# lane_regfile

Parametrised packed-lane register file for the SystemVerilog struct front-end regression suite. It holds a packed frame `{hdr, data[0:LANES-1], trl}` and provides one masked write port and one read port, both addressed by a dynamic lane index. Out-of-range accesses are deterministic and flagged, never X. A sequenced bulk-fill engine restores the fill pattern. It generalises the single-cycle dynamic-range struct tests to registered, multi-lane storage with handshake and error reporting.

## Interface
- `LANES`, 4: number of data lanes, ≥1.
- `W`, 8: lane width in bits.
- `AW`, 3: address width; 2^AW may exceed `LANES`, so out-of-range indices are reachable.
- `FILL`, all-ones W-bit value: reset/fill pattern for hdr, trl and every lane.

Ports:
- `clk_i`  in  1  clock; all state changes on the rising edge.
- `rst_i`  in  1  reset, synchronous, active-high.
- `wr_valid_i`  in  1  write request.
- `wr_addr_i`  in  AW  write lane index.
- `wr_data_i`  in  W  write data.
- `wr_mask_i`  in  W  per-bit write enable.
- `rd_valid_i`  in  1  read request.
- `rd_addr_i`  in  AW  read lane index.
- `rd_valid_o`  out  1  read response valid.
- `rd_data_o`  out  W  read data.
- `rd_oor_o`  out  1  read index was out of range.
- `fill_i`  in  1  start bulk fill (pulse).
- `busy_o`  out  1  fill in progress.
- `err_o`  out  1  sticky error.
- `clear_i`  in  1  clears `err_o`.
- `frame_o`  out  (LANES+2)*W  the full packed frame, hdr in the MSBs, lane 0 directly below hdr, trl in the LSBs.

## Operation
- **Reset.** hdr, trl and all lanes = `FILL`. `rd_valid_o` = 0, `rd_data_o` = 0, `rd_oor_o` = 0, `busy_o` = 0, `err_o` = 0. FSM = IDLE.
- **Write.** With `wr_valid_i` and `wr_addr_i` < `LANES`, the lane becomes `(old & ~mask) | (data & mask)`. hdr and trl are never writable.
- **Out-of-range write** (`wr_addr_i` ≥ `LANES`): no storage change; `err_o` is set.
- **Read, in range.** `rd_data_o` = lane contents, `rd_oor_o` = 0.
- **Read, out of range.** `rd_data_o` = 0, `rd_oor_o` = 1.
- **Idle read outputs.** When `rd_valid_i` = 0, `rd_valid_o` = 0 and `rd_data_o`/`rd_oor_o` hold their previous values.
- **FSM IDLE → SWEEP** on `fill_i`. SWEEP writes `FILL` to lane k on its k-th cycle (k = 0..LANES-1), then returns to IDLE. `fill_i` while in SWEEP is ignored.
- **Write during SWEEP.** `wr_valid_i` in SWEEP is dropped and sets `err_o`. Reads are served normally during SWEEP and see lanes already swept.
- **Error flag.** `err_o` is cleared by `clear_i` or reset. If set and clear fall in the same cycle, set wins.
- **Same-lane read and write.** Behaviour is selected by the macro (see Configuration).

## Timing
- Write is visible in storage and `frame_o` the cycle after the request.
- Read latency is 1 cycle: `rd_valid_o` is the registered `rd_valid_i`. Back-to-back reads give one response per cycle.
- `err_o` rises 1 cycle after the offending write.
- `busy_o` rises the cycle after `fill_i` and stays high exactly `LANES` cycles. Storage is fully `FILL` when `busy_o` falls.
- A reset mid-sweep returns the FSM to IDLE next cycle, with all storage at `FILL`.

## Configuration
- `LANE_REGFILE_BYPASS_EN` defined: a read and an in-range write to the same lane in the same cycle return the merged new value. The same applies to a read of the lane being swept, which returns `FILL`.
- Not defined: such a read returns the pre-write value. The storage update is identical in both builds.

## Structure
- Package `lane_regfile_pkg`:
  - FSM enum `{IDLE, SWEEP}`.
  - Default `FILL` constant.
  - Function `lane_in_range(addr, lanes)`.
- Storage is one packed struct variable, declared locally, with parametrised widths.
- Sub-module `lane_merge`: masked merge `(old, data, mask) → new`. It is instantiated once for the write path and reused for the bypass path.

## Test plan
Parameters for all scenarios: LANES=4, W=8, AW=3.
1. Reset, then read lane 2 → next cycle `rd_valid_o`=1, `rd_data_o`=8'hff, `rd_oor_o`=0. `frame_o` is all-ones.
2. Write lane 1 with 8'h7e, mask 8'hff. Then read lane 1 → 8'h7e; then read lane 2 → 8'hff.
3. Read addr 4 → `rd_data_o`=8'h00, `rd_oor_o`=1. Write addr 5 → `frame_o` unchanged, `err_o`=1 until `clear_i`.
4. Write lane 0 with 8'h00, mask 8'h0f → read lane 0 returns 8'hf0.
5. Same cycle: write lane 3 with 8'ha5, mask 8'hff, and read lane 3 → 8'ha5 with `LANE_REGFILE_BYPASS_EN`, 8'hff without. The following read returns 8'ha5 in both builds.
6. After scenario 2, pulse `fill_i` → `busy_o` high exactly 4 cycles, then lane 1 reads 8'hff. A write issued during `busy_o` sets `err_o` and changes nothing. Asserting `rst_i` mid-sweep gives `busy_o`=0 next cycle.
